msk_unmask_seq: RTL and testbench
=================================

// Module: msk_unmask_seq
// PURPOSE
// - Inverse of constant masking: recombines a d-share Boolean sharing of a count-bit word into
//   its unmasked value by XOR-folding one share per cycle.
// - Sits at the masked-core output boundary. Only non-sensitive results, e.g. ciphertext, pass
//   through it. Valid/ready handshake on both sides.
// - Serial folding keeps a single XOR level per cycle, so no combinational tree mixes shares.
// PARAMETERS
// - d      1  number of shares per bit (d >= 1)
// - count  1  number of unmasked bits per word
// PORTS
// - clk        in   1        single clock; all state updates on rising edge
// - rst        in   1        synchronous, active-high reset
// - in_shares  in   count*d  sharing; share j of bit i at in_shares[i*d+j]
// - in_valid   in   1        in_shares valid
// - in_ready   out  1        block accepts a word this cycle
// - out_data   out  count    unmasked word; bit i = XOR of its d shares
// - out_valid  out  1        out_data valid
// - out_ready  in   1        sink accepts out_data
// - busy       out  1        high in any state other than IDLE
// BEHAVIOUR
// - Reset: state=IDLE; share register, accumulator and counter are zero.
//   After reset: out_valid=0, out_data=0, busy=0, in_ready=1.
// - States:
//   - IDLE: waits for a word.
//   - FOLD: XORs one share per cycle into the accumulator.
//   - VALID: holds the result until the sink accepts it.
// - Accept rule: an accept occurs on a rising edge where in_valid & in_ready.
//   - The capture stores all shares and loads acc[i] = share 0 of bit i. cnt is set to 1.
//   - Next state: FOLD if d>1, else VALID.
// - FOLD, each cycle:
//   - acc[i] ^= share cnt of bit i. The share slot just used is cleared to 0.
//   - cnt++. Leave FOLD for VALID on the cycle that folds share d-1.
// - Latency: accept at edge T gives out_valid=1 from edge T+d. Holds for d=1: out_valid at T+1.
// - VALID:
//   - out_valid=1; out_data=acc stays stable until out_valid & out_ready.
//   - On that handshake, go to IDLE, or straight to a new capture (see below).
// - out_data is 0 whenever out_valid=0. acc is cleared on the transition out of VALID.
// - in_ready = (state==IDLE) | (state==VALID & out_ready).
//   - This is the only combinational path from out_ready to in_ready.
//   - Simultaneous output handshake and input accept in VALID: the new word is captured and the
//     state goes to FOLD, or to VALID when d=1. Back-to-back throughput is one word per d cycles.
// - in_valid and in_shares are ignored in FOLD, and in VALID while out_ready=0. No word is lost.
//   Upstream must hold the word, per the handshake.
// - Reset mid-operation (FOLD or VALID) drops the in-flight word.
//   - All share and accumulator bits are zero on the next cycle; no partial result is emitted.
// - Residual-share hygiene: after the last fold every share slot is 0. Shares never sit in the
//   register alongside the unmasked result.
// - cnt width is $clog2(d)+1. It never exceeds d-1 in FOLD.
// STRUCTURE
// - msk_pkg:
//   - state encoding localparams ST_IDLE, ST_FOLD, ST_VALID (2-bit)
//   - shared index macro/function for share j of bit i (i*d+j)
// - Sub-module msk_unmask_lane: one per bit, generated count times.
//   - Holds d share flops and 1 accumulator flop.
//   - Inputs: load, fold, clear, fold index.
//   - The top level owns the FSM, the counter and the handshake logic.
// TESTING
// - d=2,count=8: shares {a,b} with a^b=0xA5. Expect out_data=0xA5 with out_valid at T+2 and
//   busy=1 for T+1..T+2.
// - d=4,count=4: random shares, out_ready held 0 for 5 cycles. Expect out_data stable, in_ready=0,
//   a second in_valid not consumed. On release, data=0x9 and one handshake.
// - d=3: out_ready=1 and in_valid=1 continuously. Expect one result every 3 cycles, in input
//   order, no drops or duplicates over 50 words.
// - d=1,count=8: in_shares=0x3C. Expect out_valid at T+1 with out_data=0x3C.
// - rst asserted in the second FOLD cycle (d=4). Expect the next cycle state=IDLE, out_valid=0,
//   out_data=0, all share flops 0, in_ready=1.
// - After each word reaches VALID (d=3), probe share flops: all zero while out_valid=1.

Source files
------------

// File: rtl/msk_unmask_seq_pkg.sv
// Shared definitions for the serial share-folding unmasker: state encoding and share indexing.
package msk_unmask_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FOLD  = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    // Share j of bit i sits at flat position i*d+j of the input sharing.
    function automatic int share_idx(input int i, input int j, input int d);
        return i * d + j;
    endfunction

endpackage

// File: rtl/msk_unmask_seq_if.sv
// Valid/ready handshake bundle between the masked core, the unmasker and the downstream sink.
interface msk_unmask_seq_if #(
    parameter int D     = 1,
    parameter int COUNT = 1
);
    logic [COUNT*D-1:0] in_shares;
    logic               in_valid;
    logic               in_ready;
    logic [COUNT-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_shares, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_shares, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/msk_unmask_seq_lane.sv
// One unmasked bit: holds its d share flops and folds one share per cycle into the accumulator.
module msk_unmask_seq_lane
    import msk_unmask_seq_pkg::*;
#(
    parameter int D     = 1,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_fold,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [D-1:0]     i_shares,
    output logic             o_acc
);

    logic [D-1:0] r_share;
    logic         r_acc;
    logic         w_sel;

    always_comb begin
        w_sel = 1'b0;
        for (int j = 0; j < D; j++) begin
            if (i_idx == IDX_W'(j)) w_sel = r_share[j];
        end
    end

    // Slot 0 goes straight into the accumulator, so it is never kept in the share register.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_share <= '0;
            r_acc   <= 1'b0;
        end else if (i_load) begin
            r_share <= i_shares & ~D'(1);
            r_acc   <= i_shares[0];
        end else if (i_fold) begin
            r_acc <= r_acc ^ w_sel;
            for (int j = 0; j < D; j++) begin
                if (i_idx == IDX_W'(j)) r_share[j] <= 1'b0;
            end
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/msk_unmask_seq.sv
// Recombines a d-share Boolean sharing into its unmasked word, one XOR level per cycle.
module msk_unmask_seq
    import msk_unmask_seq_pkg::*;
#(
    parameter int D     = 1,
    parameter int COUNT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    msk_unmask_seq_if.slave       bus,
    output logic                  busy
);

    localparam int CNT_W = $clog2(D) + 1;
    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_accept;
    logic             w_out_hs;
    logic             w_load;
    logic             w_clear;
    logic             w_fold;
    logic [COUNT-1:0] w_acc;

    assign bus.in_ready = (r_state == ST_IDLE) | ((r_state == ST_VALID) & bus.out_ready);
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_out_hs     = r_out_valid & bus.out_ready;
    assign w_load       = w_accept & ~rst;
    // A new capture overwrites the lanes, so the accumulator only needs clearing when nothing follows.
    assign w_clear      = rst | (w_out_hs & ~w_accept);
    assign w_fold       = (r_state == ST_FOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_VALID: begin
                    if (w_accept) begin
                        r_state     <= (D > 1) ? ST_FOLD : ST_VALID;
                        r_cnt       <= CNT_W'(1);
                        r_out_valid <= (D == 1);
                        r_busy      <= 1'b1;
                    end else if (w_out_hs) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                ST_FOLD: begin
                    if (r_cnt == CNT_W'(D - 1)) begin
                        r_state     <= ST_VALID;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < COUNT; gi++) begin : g_lane
        logic [D-1:0] w_sh;
        for (genvar gj = 0; gj < D; gj++) begin : g_sh
            assign w_sh[gj] = bus.in_shares[share_idx(gi, gj, D)];
        end

        msk_unmask_seq_lane #(
            .D     (D),
            .IDX_W (IDX_W)
        ) u_lane (
            .clk      (clk),
            .i_clear  (w_clear),
            .i_load   (w_load),
            .i_fold   (w_fold),
            .i_idx    (r_cnt[IDX_W-1:0]),
            .i_shares (w_sh),
            .o_acc    (w_acc[gi])
        );
    end

    assign bus.out_data  = r_out_valid ? w_acc : '0;
    assign bus.out_valid = r_out_valid;
    assign busy          = r_busy;

endmodule

// File: tb/tb_msk_unmask_seq.sv
// Directed bench for msk_unmask_seq at d=1,2,3,4 with a per-instance scoreboard.
module tb_msk_unmask_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    msk_unmask_seq_if #(.D(2), .COUNT(8)) if_a ();
    msk_unmask_seq_if #(.D(4), .COUNT(4)) if_b ();
    msk_unmask_seq_if #(.D(3), .COUNT(8)) if_c ();
    msk_unmask_seq_if #(.D(1), .COUNT(8)) if_e ();

    logic busy_a, busy_b, busy_c, busy_e;

    msk_unmask_seq #(.D(2), .COUNT(8)) u_a (.clk(clk), .rst(rst), .bus(if_a), .busy(busy_a));
    msk_unmask_seq #(.D(4), .COUNT(4)) u_b (.clk(clk), .rst(rst), .bus(if_b), .busy(busy_b));
    msk_unmask_seq #(.D(3), .COUNT(8)) u_c (.clk(clk), .rst(rst), .bus(if_c), .busy(busy_c));
    msk_unmask_seq #(.D(1), .COUNT(8)) u_e (.clk(clk), .rst(rst), .bus(if_e), .busy(busy_e));

    logic [15:0] sh_b;
    logic [3:0]  acc_b;
    logic [23:0] sh_c;
    for (genvar gi = 0; gi < 4; gi++) begin : g_pb
        assign sh_b[gi*4 +: 4] = u_b.g_lane[gi].u_lane.r_share;
        assign acc_b[gi]       = u_b.g_lane[gi].u_lane.r_acc;
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_pc
        assign sh_c[gi*3 +: 3] = u_c.g_lane[gi].u_lane.r_share;
    end

    logic [7:0] cur_a, cur_b, cur_c, cur_e;
    logic [7:0] q_a[$], q_b[$], q_c[$], q_e[$];
    int hs_a = 0, hs_b = 0, hs_c = 0, hs_e = 0;
    int last_c = -1;
    logic stream_c = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mask_word(input logic [7:0] w, input int d, input int cnt);
        logic [63:0] s;
        logic        x;
        logic        b;
        s = '0;
        for (int i = 0; i < cnt; i++) begin
            x = 1'b0;
            for (int j = 0; j < d - 1; j++) begin
                b = 1'($urandom_range(0, 1));
                s[i*d+j] = b;
                x = x ^ b;
            end
            s[i*d+d-1] = w[i] ^ x;
        end
        return s;
    endfunction

    // Scoreboards: push on input accept, pop and compare on output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_a.out_valid && if_a.out_ready) begin
                hs_a++;
                chk("a_data", {56'd0, if_a.out_data}, (q_a.size() != 0) ? {56'd0, q_a.pop_front()} : 64'hDEAD);
            end
            if (if_a.in_valid && if_a.in_ready) q_a.push_back(cur_a);
            if (if_b.out_valid && if_b.out_ready) begin
                hs_b++;
                chk("b_data", {60'd0, if_b.out_data}, (q_b.size() != 0) ? {56'd0, q_b.pop_front()} : 64'hDEAD);
            end
            if (if_b.in_valid && if_b.in_ready) q_b.push_back(cur_b);
            if (if_e.out_valid && if_e.out_ready) begin
                hs_e++;
                chk("e_data", {56'd0, if_e.out_data}, (q_e.size() != 0) ? {56'd0, q_e.pop_front()} : 64'hDEAD);
            end
            if (if_e.in_valid && if_e.in_ready) q_e.push_back(cur_e);
            if (if_c.out_valid) chk("c_share_zero", {40'd0, sh_c}, 64'd0);
            if (if_c.out_valid && if_c.out_ready) begin
                hs_c++;
                chk("c_data", {56'd0, if_c.out_data}, (q_c.size() != 0) ? {56'd0, q_c.pop_front()} : 64'hDEAD);
                if (stream_c && last_c >= 0) chk("c_gap", 64'(cyc - last_c), 64'd3);
                last_c = cyc;
            end
            if (if_c.in_valid && if_c.in_ready) q_c.push_back(cur_c);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] m;
        int t;
        rst = 1'b1;
        cur_a = '0; cur_b = '0; cur_c = '0; cur_e = '0;
        if_a.in_valid = 0; if_a.in_shares = '0; if_a.out_ready = 0;
        if_b.in_valid = 0; if_b.in_shares = '0; if_b.out_ready = 0;
        if_c.in_valid = 0; if_c.in_shares = '0; if_c.out_ready = 0;
        if_e.in_valid = 0; if_e.in_shares = '0; if_e.out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_a_valid", 64'(if_a.out_valid), 64'd0);
        chk("rst_a_data",  64'(if_a.out_data),  64'd0);
        chk("rst_a_busy",  64'(busy_a),         64'd0);
        chk("rst_a_ready", 64'(if_a.in_ready),  64'd1);
        chk("rst_b_valid", 64'(if_b.out_valid), 64'd0);
        chk("rst_b_ready", 64'(if_b.in_ready),  64'd1);
        chk("rst_c_busy",  64'(busy_c),         64'd0);
        chk("rst_e_data",  64'(if_e.out_data),  64'd0);

        // d=2: shares {a,b} with a^b = 0xA5
        @(posedge clk); #1;
        if_a.out_ready = 1;
        cur_a = 8'hA5;
        m = mask_word(8'hA5, 2, 8);
        if_a.in_shares = m[15:0];
        if_a.in_valid = 1;
        @(posedge clk); #1;
        if_a.in_valid = 0;
        @(negedge clk);
        chk("a_busy_t1",  64'(busy_a),         64'd1);
        chk("a_valid_t1", 64'(if_a.out_valid), 64'd0);
        chk("a_data_t1",  64'(if_a.out_data),  64'd0);
        @(negedge clk);
        chk("a_busy_t2",  64'(busy_a),         64'd1);
        chk("a_valid_t2", 64'(if_a.out_valid), 64'd1);
        chk("a_val_t2",   64'(if_a.out_data),  64'hA5);
        @(negedge clk);
        chk("a_idle_busy",  64'(busy_a),         64'd0);
        chk("a_idle_valid", 64'(if_a.out_valid), 64'd0);
        chk("a_hs", 64'(hs_a), 64'd1);

        // d=1: single share equals the value
        @(posedge clk); #1;
        if_e.out_ready = 1;
        cur_e = 8'h3C;
        if_e.in_shares = 8'h3C;
        if_e.in_valid = 1;
        @(posedge clk); #1;
        if_e.in_valid = 0;
        @(negedge clk);
        chk("e_valid_t1", 64'(if_e.out_valid), 64'd1);
        chk("e_val_t1",   64'(if_e.out_data),  64'h3C);
        chk("e_busy_t1",  64'(busy_e),         64'd1);
        @(negedge clk);
        chk("e_valid_t2", 64'(if_e.out_valid), 64'd0);
        chk("e_hs", 64'(hs_e), 64'd1);

        // d=4: backpressure holds the result and blocks a second word
        @(posedge clk); #1;
        if_b.out_ready = 0;
        cur_b = 8'h09;
        m = mask_word(8'h09, 4, 4);
        if_b.in_shares = m[15:0];
        if_b.in_valid = 1;
        @(posedge clk); #1;
        if_b.in_valid = 0;
        for (int k = 0; k < 10 && if_b.out_valid !== 1'b1; k++) @(negedge clk);
        chk("b_valid", 64'(if_b.out_valid), 64'd1);
        chk("b_share_zero", 64'(sh_b), 64'd0);
        @(posedge clk); #1;
        cur_b = 8'h05;
        m = mask_word(8'h05, 4, 4);
        if_b.in_shares = m[15:0];
        if_b.in_valid = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("b_hold_data",  64'(if_b.out_data),  64'h9);
            chk("b_hold_ready", 64'(if_b.in_ready),  64'd0);
            chk("b_hold_valid", 64'(if_b.out_valid), 64'd1);
            @(posedge clk); #1;
        end
        chk("b_q_hold", 64'(q_b.size()), 64'd1);
        if_b.out_ready = 1;
        @(negedge clk);
        chk("b_rel_ready", 64'(if_b.in_ready), 64'd1);
        @(posedge clk); #1;
        if_b.in_valid = 0;
        @(negedge clk);
        chk("b_hs1", 64'(hs_b), 64'd1);
        chk("b_busy_refold", 64'(busy_b), 64'd1);
        for (int k = 0; k < 10 && if_b.out_valid !== 1'b1; k++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("b_hs2", 64'(hs_b), 64'd2);
        chk("b_q_empty", 64'(q_b.size()), 64'd0);

        // d=4: reset during the second FOLD cycle
        @(posedge clk); #1;
        cur_b = 8'h06;
        m = mask_word(8'h06, 4, 4);
        if_b.in_shares = m[15:0];
        if_b.in_valid = 1;
        @(posedge clk); #1;
        if_b.in_valid = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("r_busy",  64'(busy_b),         64'd0);
        chk("r_valid", 64'(if_b.out_valid), 64'd0);
        chk("r_data",  64'(if_b.out_data),  64'd0);
        chk("r_ready", 64'(if_b.in_ready),  64'd1);
        chk("r_share", 64'(sh_b),           64'd0);
        chk("r_acc",   64'(acc_b),          64'd0);
        q_b.delete();
        repeat (6) @(negedge clk);
        chk("r_no_emit", 64'(hs_b), 64'd2);

        // d=3: continuous stream of 50 words
        @(posedge clk); #1;
        if_c.out_ready = 1;
        stream_c = 1'b1;
        if_c.in_valid = 1;
        for (int k = 0; k < 50; k++) begin
            cur_c = 8'($urandom);
            m = mask_word(cur_c, 3, 8);
            if_c.in_shares = m[23:0];
            t = 0;
            @(negedge clk);
            while (!if_c.in_ready && t < 10) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk); #1;
        end
        if_c.in_valid = 0;
        for (int k = 0; k < 20 && q_c.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        chk("c_hs", 64'(hs_c), 64'd50);
        chk("c_q_empty", 64'(q_c.size()), 64'd0);
        chk("c_idle", 64'(busy_c), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
